// File: rtl/popcount_sched.sv
// popcount_sched: round-robin arbiter streaming operands nibble-wise through a shared one-hot popcount unit
module popcount_sched #(
  parameter int WIDTH = 16,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             pc_a,
  output logic             pc_b,
  output logic             pc_c,
  output logic             pc_d,
  input  logic             pc_v,
  input  logic             pc_w,
  input  logic             pc_x,
  input  logic             pc_y,
  input  logic             pc_z,
  output logic             res_valid,
  output logic [CW-1:0]    res_count,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
);
  localparam int N = WIDTH / 4;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;
  logic [CW-1:0]    res_count_q, res_count_d;
  logic             res_id_q, res_id_d;
  logic             err_q, err_d;
  logic             run, grant, take, onehot;
  logic [CW-1:0]    dec, sum;
  assign run = state_q == RUN;
  assign grant = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign take = (state_q == IDLE) & ena & ~reset & (req0_valid | req1_valid);
  assign req0_ready = take & ~grant;
  assign req1_ready = take & grant;
  assign onehot = $onehot({pc_v, pc_w, pc_x, pc_y, pc_z});
  assign dec = ~onehot ? CW'(0) : pc_z ? CW'(4) : pc_y ? CW'(3) : pc_x ? CW'(2) : pc_w ? CW'(1) : CW'(0);
  assign sum = acc_q + dec;
  assign {pc_d, pc_c, pc_b, pc_a} = run ? shreg_q[3:0] : 4'd0;
  assign res_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign res_count = res_count_q;
  assign res_id = res_id_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d = acc_q;
    idx_d = idx_q;
    last_d = last_q;
    res_count_d = res_count_q;
    res_id_d = res_id_q;
    err_d = err_q;
    if (take) begin
      shreg_d = grant ? req1_data : req0_data;
      acc_d = '0;
      idx_d = '0;
      last_d = grant;
      res_id_d = grant;
      state_d = RUN;
    end else if (ena && run) begin
      acc_d = sum;
      shreg_d = shreg_q >> 4;
      idx_d = idx_q + 1'b1;
      err_d = err_q | ~onehot;
      state_d = (idx_q == IW'(N - 1)) ? DONE : RUN;
      res_count_d = (idx_q == IW'(N - 1)) ? sum : res_count_q;
    end else if (ena && state_q == DONE && res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      last_q <= 1'b1;
      res_count_q <= '0;
      res_id_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      last_q <= last_d;
      res_count_q <= res_count_d;
      res_id_q <= res_id_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_popcount_sched.sv
// tb_popcount_sched: directed self-checking bench with a behavioural one-hot counter model
module tb_popcount_sched;
  logic        clk = 0;
  logic        reset = 1;
  logic        ena = 1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        pc_a, pc_b, pc_c, pc_d;
  logic        pc_v, pc_w, pc_x, pc_y, pc_z;
  logic        res_valid, res_id, res_ready = 0, busy, err;
  logic [4:0]  res_count;
  logic        bad = 0;
  logic [2:0]  pcnt;
  int          tests = 0, fails = 0;
  popcount_sched dut (
    .clk(clk), .reset(reset), .ena(ena),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pc_a(pc_a), .pc_b(pc_b), .pc_c(pc_c), .pc_d(pc_d),
    .pc_v(pc_v), .pc_w(pc_w), .pc_x(pc_x), .pc_y(pc_y), .pc_z(pc_z),
    .res_valid(res_valid), .res_count(res_count), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  assign pcnt = 3'(pc_a) + 3'(pc_b) + 3'(pc_c) + 3'(pc_d);
  assign pc_v = !bad && pcnt == 3'd0;
  assign pc_w = bad || pcnt == 3'd1;
  assign pc_x = bad || pcnt == 3'd2;
  assign pc_y = !bad && pcnt == 3'd3;
  assign pc_z = !bad && pcnt == 3'd4;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic wait_ready(input bit id);
    int n = 0;
    #1;
    while ((id ? req1_ready : req0_ready) !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready", id ? req1_ready : req0_ready, 1);
  endtask
  task automatic wait_result(input int cnt, input bit id, input int lat, input int start);
    int n = start;
    while (res_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("res_count", res_count, cnt);
    chk("res_id", res_id, id);
  endtask
  task automatic release_res();
    res_ready = 1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 0;
    chk("res_valid_fall", res_valid, 0);
    chk("busy_fall", busy, 0);
  endtask
  task automatic op(input bit id, input logic [15:0] data, input int cnt, input int lat);
    if (id) begin req1_valid = 1; req1_data = data; end
    else begin req0_valid = 1; req0_data = data; end
    wait_ready(id);
    @(posedge clk);
    @(negedge clk);
    if (id) req1_valid = 0; else req0_valid = 0;
    #1;
    chk("ready_one_cycle", {req1_ready, req0_ready}, 0);
    chk("busy_run", busy, 1);
    wait_result(cnt, id, lat, 0);
    release_res();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int n;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1;
    #1;
    chk("ready_in_reset", {req1_ready, req0_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_err", err, 0);
    chk("rst_pc", {pc_d, pc_c, pc_b, pc_a}, 0);
    req0_valid = 0;
    do_reset();
    op(0, 16'hFFFF, 16, 4);
    chk("err_clean", err, 0);
    do_reset();
    req0_valid = 1; req0_data = 16'h00F0;
    req1_valid = 1; req1_data = 16'h8001;
    #1;
    chk("tie_r0", req0_ready, 1);
    chk("tie_r1", req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    #1;
    chk("r1_wait", req1_ready, 0);
    chk("pc_first_nib", {pc_d, pc_c, pc_b, pc_a}, 0);
    wait_result(4, 0, 4, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_count", res_count, 4);
      chk("hold_id", res_id, 0);
      chk("hold_ready", {req1_ready, req0_ready}, 0);
      chk("hold_pc", {pc_d, pc_c, pc_b, pc_a}, 0);
    end
    release_res();
    chk("count_kept", res_count, 4);
    req0_valid = 1;
    #1;
    chk("rr_r1", req1_ready, 1);
    chk("rr_r0", req0_ready, 0);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    wait_result(2, 1, 4, 0);
    release_res();
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    wait_result(4, 0, 4, 0);
    release_res();
    req0_valid = 1; req0_data = 16'h1234;
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_pc", {pc_d, pc_c, pc_b, pc_a}, 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_result", res_valid, 0);
    end
    op(0, 16'h0000, 0, 4);
    ena = 0; req0_valid = 1; req0_data = 16'hA5A5;
    #1;
    chk("ena_low_ready", req0_ready, 0);
    ena = 1;
    #1;
    chk("ena_high_ready", req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    chk("ena_nib0", {pc_d, pc_c, pc_b, pc_a}, 5);
    @(negedge clk);
    n = 1;
    chk("ena_nib1", {pc_d, pc_c, pc_b, pc_a}, 10);
    ena = 0;
    repeat (3) begin
      @(negedge clk);
      n++;
      chk("ena_pc_hold", {pc_d, pc_c, pc_b, pc_a}, 10);
      chk("ena_busy", busy, 1);
      chk("ena_no_result", res_valid, 0);
    end
    ena = 1;
    wait_result(8, 0, 7, n);
    release_res();
    req0_valid = 1; req0_data = 16'hFFFF;
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    bad = 1;
    @(negedge clk);
    bad = 0;
    chk("err_set", err, 1);
    wait_result(12, 0, 4, 1);
    release_res();
    chk("err_sticky", err, 1);
    op(1, 16'h0003, 2, 4);
    chk("err_sticky2", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/popcount_sched.md
# popcount_sched

Controller that shares one 4-input one-hot population counter (inputs a..d, outputs v..z for counts 0..4) between two requesters. It grants one request at a time by round-robin arbitration, streams the granted WIDTH-bit operand through the counter one nibble per cycle, and accumulates the total. It returns the bit count with a valid/ready result handshake. It sits between the requesting logic and the single counter instance, which it drives combinationally.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4. Define N = WIDTH/4.
- CW, $clog2(WIDTH+1), width of the result count.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  clock enable; when low, all state holds.
- req0_valid  in  1  requester 0 has an operand.
- req0_data  in  WIDTH  operand from requester 0.
- req0_ready  out  1  requester 0 operand is accepted this cycle.
- req1_valid, req1_data, req1_ready  same as the req0 ports, for requester 1.
- pc_a, pc_b, pc_c, pc_d  out  1 each  nibble driven to the shared counter; a=bit0, b=bit1, c=bit2, d=bit3.
- pc_v, pc_w, pc_x, pc_y, pc_z  in  1 each  one-hot count from the counter (0,1,2,3,4), same cycle, combinational.
- res_valid  out  1  result available.
- res_count  out  CW  number of set bits in the operand.
- res_id  out  1  index of the requester that owns the result.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in RUN or DONE.
- err  out  1  sticky flag: a non-one-hot counter output was seen.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Arbitration happens in IDLE only:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not in `last` is granted.
  - reqN_ready = (state==IDLE) & ena & ~reset & grant==N.
  - The ready signal depends combinationally on both valid inputs. At most one ready is high.
- On a handshake (valid & ready):
  - Capture the data into the shift register.
  - Set acc=0, idx=0, `last`=N and res_id=N.
  - Go to RUN.
- RUN:
  - pc_a..d = shreg[3:0].
  - Decode the counter output: v→0, w→1, x→2, y→3, z→4.
  - acc += decoded value; shreg >>= 4; idx++.
  - When idx==N-1 is being processed, go to DONE at the end of that cycle. At the same edge, load res_count with the final sum (acc + current decoded value).
- Counter output that is not exactly one-hot: add 0 and set err=1. err is cleared only by reset.
- DONE:
  - res_valid=1; res_count and res_id are stable.
  - When res_valid & res_ready, go to IDLE.
- pc_a..d drive 0 whenever the state is not RUN.
- Arithmetic: acc is CW bits wide and cannot overflow, because the maximum value is WIDTH.

## Timing
- Reset values: state IDLE, res_valid 0, res_count 0, res_id 0, busy 0, err 0, pc_a..d 0, acc 0, idx 0, `last`=1 (so requester 0 wins the first tie). Both readies are 0 while reset is high.
- A reset asserted mid-RUN or mid-DONE aborts the operation. Outputs take their reset values at the next edge, and no result is produced.
- Latency: handshake at edge T, RUN occupies cycles T..T+N-1, and res_valid rises at edge T+N (4 cycles for WIDTH=16).
- Result handshake at edge R: res_valid falls at R. The earliest next accept is at edge R+1, because the state must be IDLE for a full cycle.
- Throughput: one operand every N+2 cycles when res_ready is held high.
- ena low: the FSM, acc, shreg, idx and err all hold. readies are 0 and pc_a..d hold their value. Latency extends by the number of ena-low cycles.
- Results are single-buffered. While in RUN or DONE, both readies are 0 and requests wait.
- res_count and res_id hold their last value after DONE until the next result is loaded.

## Test plan
- Reset, then req0 data 0xFFFF → req0_ready high 1 cycle; res_valid 4 cycles later; res_count=16, res_id=0, err=0.
- req0=0x00F0 and req1=0x8001 valid together from reset → req0 served first (count 4, id 0), then req1 (count 2, id 1). Both valid again → req1 (last was 0) is granted.
- Hold res_ready low 5 cycles in DONE → res_valid, res_count and res_id are stable. req0_ready and req1_ready stay 0.
- reset pulsed at the 2nd RUN cycle → next cycle state IDLE, busy 0, res_valid 0. No result is emitted. A fresh request (0x0000) gives count 0.
- ena low 3 cycles mid-RUN with operand 0xA5A5 → res_valid at 4+3 cycles after accept; res_count=8.
- Counter model forced to assert pc_w and pc_x together on one nibble → err=1 and stays 1 through later operations until reset. That nibble contributes 0.
